// File: rtl/alu_issue_arbiter_pkg.sv
// Shared opcode constants and request record for the ALU issue arbiter.
package alu_issue_arbiter_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  localparam int ALU_DATA_W = 64;
  // Tag field width carried through the request record; the top's TAG_W must not exceed it.
  localparam int ALU_TAG_W  = 4;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [2:0]            cntrl;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_req_t;

  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_alu.sv
// Combinational 64-bit ALU: pass/add/sub/and/or/xor with N/Z/V/C flags.
module alu_issue_arbiter_alu
  import alu_issue_arbiter_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] a,
  input  logic [ALU_DATA_W-1:0] b,
  input  logic [2:0]            cntrl,
  output logic [ALU_DATA_W-1:0] result,
  output logic                  negative,
  output logic                  zero,
  output logic                  overflow,
  output logic                  carry,
  output logic                  illegal
);

  logic [ALU_DATA_W:0] sum;
  logic [ALU_DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1 so carry means "no borrow" (a >= b unsigned).
  assign diff = {1'b0, a} + {1'b0, ~b} + {{ALU_DATA_W{1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    carry    = 1'b0;
    case (cntrl)
      ALU_PASS_B:   result = b;
      ALU_ADD: begin
        result   = sum[ALU_DATA_W-1:0];
        carry    = sum[ALU_DATA_W];
        overflow = (a[63] == b[63]) && (sum[63] != a[63]);
      end
      ALU_SUBTRACT: begin
        result   = diff[ALU_DATA_W-1:0];
        carry    = diff[ALU_DATA_W];
        overflow = (a[63] != b[63]) && (diff[63] != a[63]);
      end
      ALU_AND:      result = a & b;
      ALU_OR:       result = a | b;
      ALU_XOR:      result = a ^ b;
      default:      result = '0;
    endcase
  end

  assign negative = result[ALU_DATA_W-1];
  assign zero     = (result == '0);
  assign illegal  = is_illegal(cntrl);

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of one ALU with a registered result slot.
// Optional ALU_ISSUE_ARBITER_STATS_EN adds saturating grant/stall counters.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][ALU_DATA_W-1:0] req_a,
  input  logic [1:0][ALU_DATA_W-1:0] req_b,
  input  logic [1:0][2:0]            req_cntrl,
  input  logic [1:0][TAG_W-1:0]      req_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ALU_DATA_W-1:0]      res_data,
  output logic                       res_negative,
  output logic                       res_zero,
  output logic                       res_overflow,
  output logic                       res_carry,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_src,
  output logic                       res_illegal
`ifdef ALU_ISSUE_ARBITER_STATS_EN
  ,
  output logic [15:0]                grant_cnt0,
  output logic [15:0]                grant_cnt1,
  output logic [15:0]                stall_cnt
`endif
);

  logic     rr_ptr;
  logic     slot_free;
  logic     gnt;
  logic     gnt_idx;
  alu_req_t sel;

  logic [ALU_DATA_W-1:0] alu_result;
  logic alu_n, alu_z, alu_v, alu_c, alu_ill;

  assign slot_free = !res_valid || res_ready;

  // Reset gates the grant so req_ready stays low while reset is held.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = 1'b0;
    if (!reset && slot_free) begin
      if (&req_valid) begin
        gnt     = 1'b1;
        gnt_idx = rr_ptr;
      end else if (req_valid[0]) begin
        gnt     = 1'b1;
        gnt_idx = 1'b0;
      end else if (req_valid[1]) begin
        gnt     = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  assign req_ready = gnt ? (2'b01 << gnt_idx) : 2'b00;

  always_comb begin
    sel       = '0;
    sel.a     = req_a[gnt_idx];
    sel.b     = req_b[gnt_idx];
    sel.cntrl = req_cntrl[gnt_idx];
    sel.tag   = ALU_TAG_W'(req_tag[gnt_idx]);
  end

  alu_issue_arbiter_alu u_alu (
    .a        (sel.a),
    .b        (sel.b),
    .cntrl    (sel.cntrl),
    .result   (alu_result),
    .negative (alu_n),
    .zero     (alu_z),
    .overflow (alu_v),
    .carry    (alu_c),
    .illegal  (alu_ill)
  );

  // A grant always reloads the slot, which also covers pop-and-grant in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_negative <= 1'b0;
      res_zero     <= 1'b0;
      res_overflow <= 1'b0;
      res_carry    <= 1'b0;
      res_tag      <= '0;
      res_src      <= 1'b0;
      res_illegal  <= 1'b0;
    end else if (gnt) begin
      rr_ptr       <= !gnt_idx;
      res_valid    <= 1'b1;
      res_data     <= alu_result;
      res_negative <= alu_n;
      res_zero     <= alu_z;
      res_overflow <= alu_v;
      res_carry    <= alu_c;
      res_tag      <= TAG_W'(sel.tag);
      res_src      <= gnt_idx;
      res_illegal  <= alu_ill;
    end else if (res_ready) begin
      res_valid    <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (gnt && !gnt_idx && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt && gnt_idx && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
      if (|req_valid && !gnt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_alu_issue_arbiter;
  localparam int TAG_W = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0][63:0]      req_a = '0;
  logic [1:0][63:0]      req_b = '0;
  logic [1:0][2:0]       req_cntrl = '0;
  logic [1:0][TAG_W-1:0] req_tag = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [63:0]           res_data;
  logic                  res_negative, res_zero, res_overflow, res_carry;
  logic [TAG_W-1:0]      res_tag;
  logic                  res_src, res_illegal;
`ifdef ALU_ISSUE_ARBITER_STATS_EN
  logic [15:0]           grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cntrl(req_cntrl), .req_tag(req_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_negative(res_negative), .res_zero(res_zero),
    .res_overflow(res_overflow), .res_carry(res_carry),
    .res_tag(res_tag), .res_src(res_src), .res_illegal(res_illegal)
`ifdef ALU_ISSUE_ARBITER_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected result record: data, N, Z, V, C, illegal.
  typedef struct packed {
    logic [63:0] d;
    logic n, z, v, c, ill;
  } exp_t;

  function automatic exp_t ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [64:0] w;
    e = '0;
    case (op)
      3'b000: e.d = b;
      3'b010: begin
        w = {1'b0, a} + {1'b0, b};
        e.d = w[63:0];
        e.c = w[64];
        w = {a[63], a} + {b[63], b};
        e.v = w[64] ^ w[63];
      end
      3'b011: begin
        e.d = a - b;
        e.c = (a >= b);
        w = {a[63], a} - {b[63], b};
        e.v = w[64] ^ w[63];
      end
      3'b100: e.d = a & b;
      3'b101: e.d = a | b;
      3'b110: e.d = a ^ b;
      default: e.ill = 1'b1;
    endcase
    e.n = e.d[63];
    e.z = (e.d == 64'd0);
    return e;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h7fffffffffffffff;
      3: return 64'h8000000000000000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] t);
    req_cntrl[i] = op;
    req_a[i]     = a;
    req_b[i]     = b;
    req_tag[i]   = t;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 2'b00)
      begin errors++; $display("FAIL reset_ctrl got valid=%b ready=%b want 0/00", res_valid, req_ready); end
    checks++;
    if ({res_data, res_negative, res_zero, res_overflow, res_carry, res_tag, res_src, res_illegal} !== '0)
      begin errors++; $display("FAIL reset_outputs got data=%h tag=%h src=%b want zeros", res_data, res_tag, res_src); end
`ifdef ALU_ISSUE_ARBITER_STATS_EN
    checks++;
    if ({grant_cnt0, grant_cnt1, stall_cnt} !== '0)
      begin errors++; $display("FAIL reset_stats got %h %h %h want 0", grant_cnt0, grant_cnt1, stall_cnt); end
`endif
  endtask

  task automatic test_round_robin();
    set_req(0, 3'b000, 64'd0, 64'haaaa, 4'h1);
    set_req(1, 3'b000, 64'd0, 64'hbbbb, 4'h2);
    reset = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== (2'b01 << (k % 2)))
        begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 2'b01 << (k % 2)); end
      checks++;
      if (res_valid !== (k != 0))
        begin errors++; $display("FAIL rr_valid%0d got %b want %b", k, res_valid, k != 0); end
      if (k > 0) begin
        checks++;
        if (res_src !== 1'((k - 1) % 2) || res_data !== req_b[(k - 1) % 2])
          begin errors++; $display("FAIL rr_src%0d got %b/%h want %0d", k, res_src, res_data, (k - 1) % 2); end
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0)
      begin errors++; $display("FAIL rr_pop got %b want 0", res_valid); end
  endtask

  task automatic test_add_overflow();
    do_reset();
    set_req(0, 3'b010, 64'h7fffffffffffffff, 64'd1, 4'h5);
    req_valid = 2'b01;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if ({res_valid, res_data, res_negative, res_zero, res_overflow, res_carry, res_illegal, res_src, res_tag}
        !== {1'b1, 64'h8000000000000000, 5'b10100, 1'b0, 4'h5})
      begin errors++; $display("FAIL add_ovf got v=%b d=%h nzvc=%b%b%b%b src=%b tag=%h", res_valid, res_data,
        res_negative, res_zero, res_overflow, res_carry, res_src, res_tag); end
  endtask

  task automatic test_sub_zero();
    set_req(1, 3'b011, 64'h2dab324f789f34ff, 64'h2dab324f789f34ff, 4'h9);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10)
      begin errors++; $display("FAIL sub_grant got %b want 10", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if ({res_valid, res_data, res_negative, res_zero, res_overflow, res_carry, res_illegal, res_src, res_tag}
        !== {1'b1, 64'd0, 5'b01010, 1'b1, 4'h9})
      begin errors++; $display("FAIL sub_zero got v=%b d=%h nzvc=%b%b%b%b src=%b tag=%h", res_valid, res_data,
        res_negative, res_zero, res_overflow, res_carry, res_src, res_tag); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_req(0, 3'b010, 64'd1, 64'd2, 4'h1);
    set_req(1, 3'b110, 64'hf0f0, 64'h0ff0, 4'h2);
    req_valid = 2'b11;
    res_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 2'b00 || res_data !== 64'd3 || res_src !== 1'b0 || res_tag !== 4'h1)
        begin errors++; $display("FAIL hold%0d got v=%b rdy=%b d=%h src=%b", k, res_valid, req_ready, res_data, res_src); end
      @(posedge clk);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10)
      begin errors++; $display("FAIL release_grant got %b want 10", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (res_valid !== 1'b1 || res_src !== 1'b1 || res_data !== 64'hff00 || res_tag !== 4'h2)
      begin errors++; $display("FAIL pop_grant got v=%b src=%b d=%h want 1/1/ff00", res_valid, res_src, res_data); end
  endtask

  task automatic test_illegal_and();
    do_reset();
    set_req(0, 3'b111, '1, '1, 4'h3);
    req_valid = 2'b01;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_req(0, 3'b100, '1, '1, 4'h4);
    checks++;
    if ({res_data, res_negative, res_zero, res_overflow, res_carry, res_illegal} !== {64'd0, 5'b01001})
      begin errors++; $display("FAIL illegal got d=%h nzvc=%b%b%b%b ill=%b", res_data,
        res_negative, res_zero, res_overflow, res_carry, res_illegal); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if ({res_data, res_negative, res_zero, res_overflow, res_carry, res_illegal} !== {64'hffffffffffffffff, 5'b10000})
      begin errors++; $display("FAIL and_ones got d=%h nzvc=%b%b%b%b ill=%b", res_data,
        res_negative, res_zero, res_overflow, res_carry, res_illegal); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 3'b101, 64'h1, 64'h2, 4'h6);
    set_req(1, 3'b101, 64'h4, 64'h8, 4'h7);
    req_valid = 2'b11;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1)
      begin errors++; $display("FAIL mid_load got %b want 1", res_valid); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 2'b00)
      begin errors++; $display("FAIL mid_reset got v=%b rdy=%b want 0/00", res_valid, req_ready); end
`ifdef ALU_ISSUE_ARBITER_STATS_EN
    checks++;
    if ({grant_cnt0, grant_cnt1, stall_cnt} !== '0)
      begin errors++; $display("FAIL mid_stats got %h %h %h want 0", grant_cnt0, grant_cnt1, stall_cnt); end
`endif
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01)
      begin errors++; $display("FAIL post_reset_grant got %b want 01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checks++;
    if (res_valid !== 1'b1 || res_src !== 1'b0 || res_data !== 64'h3)
      begin errors++; $display("FAIL post_reset_result got v=%b src=%b d=%h", res_valid, res_src, res_data); end
  endtask

  task automatic test_random();
    logic             mv, mrr, msrc, g, gi;
    exp_t             me;
    logic [TAG_W-1:0] mtag;
    logic [1:0]       held;
    int               mg0, mg1, mst;
    do_reset();
    mv = 1'b0; mrr = 1'b0; msrc = 1'b0; me = '0; mtag = '0; held = 2'b00;
    mg0 = 0; mg1 = 0; mst = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== mv)
        begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, res_valid, mv); end
      if (mv) begin
        checks++;
        if ({res_data, res_negative, res_zero, res_overflow, res_carry, res_illegal, res_tag, res_src} !== {me, mtag, msrc})
          begin errors++; $display("FAIL rnd_result cyc %0d got d=%h f=%b%b%b%b%b tag=%h src=%b want d=%h f=%b tag=%h src=%b",
            cyc, res_data, res_negative, res_zero, res_overflow, res_carry, res_illegal, res_tag, res_src,
            me.d, {me.n, me.z, me.v, me.c, me.ill}, mtag, msrc); end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (held[i]) begin
          if ($urandom_range(0, 4) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, 3'($urandom_range(0, 7)), rand64(), rand64(), TAG_W'($urandom));
        end
      end
      #1;
      g = 1'b0; gi = 1'b0;
      if (!mv || res_ready) begin
        if (req_valid == 2'b11) begin g = 1'b1; gi = mrr; end
        else if (req_valid[0]) begin g = 1'b1; gi = 1'b0; end
        else if (req_valid[1]) begin g = 1'b1; gi = 1'b1; end
      end
      checks++;
      if (req_ready !== (g ? (2'b01 << gi) : 2'b00))
        begin errors++; $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, req_ready, g ? (2'b01 << gi) : 2'b00); end
      for (int i = 0; i < 2; i++) held[i] = req_valid[i] && !(g && gi == 1'(i));
      if (g && !gi) mg0++;
      if (g && gi) mg1++;
      if (|req_valid && !g) mst++;
      if (g) begin
        me = ref_alu(req_cntrl[gi], req_a[gi], req_b[gi]);
        mtag = req_tag[gi];
        msrc = gi;
        mv = 1'b1;
        mrr = !gi;
      end else if (res_ready) begin
        mv = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
`ifdef ALU_ISSUE_ARBITER_STATS_EN
    checks++;
    if (grant_cnt0 !== 16'(mg0) || grant_cnt1 !== 16'(mg1) || stall_cnt !== 16'(mst))
      begin errors++; $display("FAIL rnd_stats got %0d %0d %0d want %0d %0d %0d",
        grant_cnt0, grant_cnt1, stall_cnt, mg0, mg1, mst); end
`endif
    checks++;
    if (res_valid !== mv)
      begin errors++; $display("FAIL rnd_final_valid got %b want %b", res_valid, mv); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_add_overflow();
    test_sub_zero();
    test_back_pressure();
    test_illegal_and();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
- REQ-001: Parameter TAG_W, default 4, width of the per-request destination tag.
- REQ-002: clk  input  1  sole clock; all state updates on posedge clk.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: req_valid  input  2  per-requester operation valid (index 0/1).
- REQ-005: req_ready  output  2  per-requester grant; a transfer occurs when req_valid[i] & req_ready[i].
- REQ-006: req_a, req_b  input  2x64  per-requester operands.
- REQ-007: req_cntrl  input  2x3  per-requester ALU opcode (000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor).
- REQ-008: req_tag  input  2xTAG_W  per-requester destination tag.
- REQ-009: res_valid  output  1  result register holds a valid result.
- REQ-010: res_ready  input  1  consumer accepts; a pop occurs when res_valid & res_ready.
- REQ-011: res_data  output  64  registered ALU result.
- REQ-012: res_negative, res_zero, res_overflow, res_carry  output  1 each  registered flags.
- REQ-013: res_tag  output  TAG_W  tag of the granted request; res_src  output  1  winning requester index.
- REQ-014: res_illegal  output  1  granted opcode was 001 or 111.

Function
- REQ-015: At most one req_ready bit SHALL be high per cycle; req_ready is combinational from req_valid, rr_ptr and slot_free.
- REQ-016: slot_free = !res_valid | res_ready; no grant SHALL be issued while !slot_free.
- REQ-017: Arbitration SHALL be round-robin: when both valid, grant goes to rr_ptr; when one valid, grant goes to that requester regardless of rr_ptr.
- REQ-018: On a grant to requester i, rr_ptr SHALL become !i on the next edge; rr_ptr SHALL be unchanged without a grant.
- REQ-019: Granted operands SHALL drive the ALU combinationally; the result, flags, tag, src and illegal SHALL be captured at the grant edge: latency exactly 1 cycle, throughput 1 op/cycle under continuous res_ready.
- REQ-020: Simultaneous pop and grant in the same cycle SHALL load the new result; res_valid stays 1.
- REQ-021: Pop without grant SHALL clear res_valid; held outputs SHALL remain stable while res_valid & !res_ready.
- REQ-022: res_overflow and res_carry SHALL be forced 0 for opcodes other than 010/011.
- REQ-023: Illegal opcodes SHALL be accepted, with res_data = 0, res_zero = 1, all other flags 0 and res_illegal = 1.
- REQ-024: A requester SHALL keep its inputs stable while req_valid & !req_ready; dropping req_valid before grant is permitted and loses no state.

Reset
- REQ-025: While reset is high: res_valid = 0, rr_ptr = 0 (requester 0 first), req_ready = 0, and res_data/flags/tag/src/illegal = 0.
- REQ-026: Reset mid-operation SHALL discard any held result without a pop; the first grant after reset is taken in the cycle after reset deasserts.

Configuration
- REQ-027: Macro ALU_ISSUE_ARBITER_STATS_EN, when defined, SHALL add outputs grant_cnt0 and grant_cnt1 (16 bits each, saturating at 16'hFFFF, cleared by reset, +1 per grant to that requester), plus stall_cnt (16 bits, saturating, +1 per cycle with any req_valid and no grant).
- REQ-028: Without ALU_ISSUE_ARBITER_STATS_EN, these ports and counters SHALL be absent, with functional behaviour identical.

Structure
- REQ-029: A shared package SHALL hold the opcode constants (ALU_PASS_B, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR) and a typedef alu_req_t {a, b, cntrl, tag}.
- REQ-030: The existing alu SHALL be instantiated once as the sole sub-module; arbitration and the output register are local logic.

Verification
- REQ-031: Reset, then req_valid = 2'b11 held, res_ready = 1 -> grants alternate 0,1,0,1; res_valid is first seen the cycle after the first grant.
- REQ-032: Requester 0 add, A = 64'h7fffffffffffffff, B = 1 -> res_data = 64'h8000000000000000, overflow = 1, negative = 1, carry = 0, next cycle.
- REQ-033: Requester 1 sub, A = B = 64'h2dab324f789f34ff -> res_data = 0, zero = 1, carry = 1, res_src = 1, tag echoed.
- REQ-034: res_ready = 0 for 3 cycles with both requesters valid -> one result held stable, req_ready = 0 after the first load; on release, pop and grant occur in the same cycle.
- REQ-035: Opcode 3'b111 with A = B = 64'hffffffffffffffff -> res_illegal = 1, res_data = 0, zero = 1; AND opcode with the same operands -> res_data = all ones, carry = 0, overflow = 0.
- REQ-036: Assert reset while res_valid = 1 and both requesters valid -> res_valid = 0 next cycle; requester 0 is granted first after reset; with STATS_EN, counters read 0.
